// File: rtl/regfile_if.sv
// Write/read bus of the architectural register file: one write port, two read ports.
interface regfile_if #(parameter int WIDTH = 32);
  logic             ctrl_writeEnable;
  logic [4:0]       ctrl_writeReg;
  logic [4:0]       ctrl_readRegA;
  logic [4:0]       ctrl_readRegB;
  logic [WIDTH-1:0] data_writeReg;
  logic [WIDTH-1:0] data_readRegA;
  logic [WIDTH-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
    output data_readRegA, data_readRegB
  );
endinterface

// File: rtl/regfile.sv
// 32 x WIDTH register file, r0 hardwired to zero, synchronous reset, two combinational
// read ports with optional same-cycle write-through.
module regfile #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic      clock,
  input  logic      ctrl_reset,
  regfile_if.slave  rf
);

  logic [31:0]      chosen;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [WIDTH-1:0] r [1:31];
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;
  logic             wr_live;
  logic             byp_a;
  logic             byp_b;

  always_comb begin
    chosen = 32'd1 << rf.ctrl_writeReg;
    sel_a  = 32'd1 << rf.ctrl_readRegA;
    sel_b  = 32'd1 << rf.ctrl_readRegB;
  end

  // chosen[0] is deliberately unused: r0 has no storage
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) r[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (chosen[i] && rf.ctrl_writeEnable) r[i] <= rf.data_writeReg;
      end
    end
  end

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 1; i < 32; i++) begin
      if (sel_a[i]) stored_a = stored_a | r[i];
      if (sel_b[i]) stored_b = stored_b | r[i];
    end
  end

  // Forwarding only for a write that will actually land on the next edge
  assign wr_live = rf.ctrl_writeEnable && !ctrl_reset && (rf.ctrl_writeReg != 5'd0);
  assign byp_a   = BYPASS && wr_live && (rf.ctrl_readRegA == rf.ctrl_writeReg);
  assign byp_b   = BYPASS && wr_live && (rf.ctrl_readRegB == rf.ctrl_writeReg);

  assign rf.data_readRegA = byp_a ? rf.data_writeReg : stored_a;
  assign rf.data_readRegB = byp_b ? rf.data_writeReg : stored_b;

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench: BYPASS=0 and BYPASS=1 instances driven in lockstep against a register-array model.
module tb_regfile;
  logic clock = 1'b0;
  logic ctrl_reset;

  always #5 clock = ~clock;

  regfile_if #(.WIDTH(32)) bus0 ();
  regfile_if #(.WIDTH(32)) bus1 ();

  regfile #(.WIDTH(32), .BYPASS(1'b0)) u_dut0 (.clock(clock), .ctrl_reset(ctrl_reset), .rf(bus0));
  regfile #(.WIDTH(32), .BYPASS(1'b1)) u_dut1 (.clock(clock), .ctrl_reset(ctrl_reset), .rf(bus1));

  typedef struct {
    logic [31:0] a0, b0, a1, b1;
    logic [4:0]  ra, rb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m[32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [4:0] idx, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h expected=%h", name, idx, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the reads the spec demands before the edge, then advance the model.
  task automatic cyc(input logic rst, input logic we, input logic [4:0] wr, input logic [4:0] ra,
                     input logic [4:0] rb, input logic [31:0] wd, input bit push = 1'b1);
    exp_t e;
    bit   live;
    @(posedge clock); #1;
    ctrl_reset = rst;
    bus0.ctrl_writeEnable = we; bus1.ctrl_writeEnable = we;
    bus0.ctrl_writeReg = wr;    bus1.ctrl_writeReg = wr;
    bus0.ctrl_readRegA = ra;    bus1.ctrl_readRegA = ra;
    bus0.ctrl_readRegB = rb;    bus1.ctrl_readRegB = rb;
    bus0.data_writeReg = wd;    bus1.data_writeReg = wd;
    live = we && !rst && (wr != 0);
    e.ra = ra; e.rb = rb;
    e.a0 = m[ra];
    e.b0 = m[rb];
    e.a1 = (live && ra == wr) ? wd : m[ra];
    e.b1 = (live && rb == wr) ? wd : m[rb];
    if (push) q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
    end else if (we && wr != 0) begin
      m[wr] = wd;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("byp0_portA", e.ra, bus0.data_readRegA, e.a0);
        chk("byp0_portB", e.rb, bus0.data_readRegB, e.b0);
        chk("byp1_portA", e.ra, bus1.data_readRegA, e.a1);
        chk("byp1_portB", e.rb, bus1.data_readRegB, e.b1);
      end
    end
  end

  initial begin : stim
    logic [4:0]  wr, ra, rb;
    logic [31:0] wd;
    logic        we, rst;
    ctrl_reset = 1'b1;
    bus0.ctrl_writeEnable = 1'b0; bus1.ctrl_writeEnable = 1'b0;
    bus0.ctrl_writeReg = '0; bus1.ctrl_writeReg = '0;
    bus0.ctrl_readRegA = '0; bus1.ctrl_readRegA = '0;
    bus0.ctrl_readRegB = '0; bus1.ctrl_readRegB = '0;
    bus0.data_writeReg = '0; bus1.data_writeReg = '0;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;

    // Power-up contents are unknown until reset is sampled, so that cycle is not checked.
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);

    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 5'(i), 5'(31 - i), 32'd0);

    cyc(1'b0, 1'b1, 5'd5,  5'd0, 5'd0, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 5'd31, 5'd0, 5'd0, 32'h12345678);
    cyc(1'b0, 1'b0, 5'd0,  5'd5, 5'd31, 32'd0);
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 5'(i), 5'(i), 32'd0);

    cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);

    cyc(1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5);
    cyc(1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 32'd0);

    cyc(1'b0, 1'b1, 5'd9, 5'd0, 5'd0, 32'h1);
    cyc(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h2);
    cyc(1'b0, 1'b0, 5'd0, 5'd9, 5'd9, 32'd0);

    cyc(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h11);
    cyc(1'b1, 1'b1, 5'd3, 5'd3, 5'd9, 32'h55);
    cyc(1'b0, 1'b0, 5'd0, 5'd3, 5'd9, 32'd0);
    cyc(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h55);
    cyc(1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 32'd0);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 29) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wr  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) wr = 5'd0;
      cyc(rst, we, wr, ra, rb, wd);
    end

    cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
